// File: rtl/case_3_acc_15s_24s.sv
// rtl/case_3_acc_15s_24s.sv - signed product-stream accumulator (dot-product reduction stage)
//
// Ports:
//   ap_clk, ap_rst      clock (rising edge), asynchronous active-high reset
//   start, len          begin a block of len products (len sampled when start is taken)
//   in_data/in_valid/in_ready     product input handshake (signed IN_WIDTH)
//   out_data/out_valid/out_ready  result output handshake (signed ACC_WIDTH)
//   busy                high while accumulating or holding a result
//   ovf                 sticky overflow flag for the current/last block
//
// Optional build macro: CASE_3_ACC_SAT_EN (saturate on overflow instead of wrapping).

module case_3_acc_15s_24s #(
    parameter int IN_WIDTH  = 15,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [ACC_WIDTH-1:0]   acc, acc_n;
    logic [LEN_WIDTH-1:0]   cnt, cnt_n;
    logic                   ovf_q, ovf_n;
    logic                   load;

    // One guard bit above the accumulator: the two top bits disagree exactly
    // when the signed add left the ACC_WIDTH range.
    logic [ACC_WIDTH:0]     sum;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   add_result;

    assign sum     = {acc[ACC_WIDTH-1], acc}
                   + {{(ACC_WIDTH + 1 - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

`ifdef CASE_3_ACC_SAT_EN
    // The guard bit carries the true sign of the sum, so it picks the rail.
    always_comb begin
        add_result = sum[ACC_WIDTH-1:0];
        if (sum_ovf) begin
            add_result = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign add_result = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf_q <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) load = 1'b1;
            end
            ACC: begin
                // in_ready is asserted throughout ACC, so in_valid alone is a transfer.
                if (in_valid) begin
                    acc_n = add_result;
                    if (sum_ovf) ovf_n = 1'b1;
                    cnt_n = cnt - LEN_WIDTH'(1);
                    if (cnt == LEN_WIDTH'(1)) state_n = DONE;
                end
            end
            DONE: begin
                // A start coinciding with the result handoff opens the next block directly.
                if (out_ready) begin
                    if (start) load = 1'b1;
                    else       state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            acc_n   = '0;
            ovf_n   = 1'b0;
            cnt_n   = len;
            state_n = (len != '0) ? ACC : DONE;
        end
    end

    // Handshake flags decode from the state register only.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC) || (state == DONE);
    assign out_data  = acc;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_case_3_acc_15s_24s.sv
// tb/tb_case_3_acc_15s_24s.sv - directed self-checking bench for case_3_acc_15s_24s

module tb_case_3_acc_15s_24s;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [14:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid, busy, ovf;
    logic [23:0] out_data;

    logic        b_in_ready, b_out_valid, b_busy, b_ovf;
    logic [15:0] b_out_data;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    case_3_acc_15s_24s dut (
        .ap_clk(clk), .ap_rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    case_3_acc_15s_24s #(.ACC_WIDTH(16)) dut16 (
        .ap_clk(clk), .ap_rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .busy(b_busy), .ovf(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] held_data;
        rst = 1'b1; start = 1'b0; len = 8'd0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Block of 3: 100 - 50 + 8192 = 8242
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 15'd100;
        tick();
        chk("t1_in_ready2", 32'(in_ready), 32'd1);
        in_data = 15'h7FCE;   // -50
        tick();
        chk("t1_in_ready3", 32'(in_ready), 32'd1);
        in_data = 15'd8192;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'd8242);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_out_valid_after", 32'(out_valid), 32'd0);

        // Block of 4 with gaps: -1 -2 -3 -4 = -10
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? 15'(-(i / 2 + 1)) : 15'h1234;
            tick();
            if (i == 5) chk("t2_not_done_early", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_data", 32'(out_data), 32'h00FFFFF6);
        chk("t2_ovf", 32'(ovf), 32'd0);
        held_data = out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_data", 32'(out_data), 32'h00FFFFF6);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // len = 0: immediate zero result
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_out_data", 32'(out_data), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_busy_after", 32'(busy), 32'd0);

        // 16383 x 4: 16-bit instance overflows, 24-bit instance does not
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 15'd16383;
        repeat (4) tick();
        in_valid = 1'b0;
`ifdef CASE_3_ACC_SAT_EN
        chk("t4p_b_data", 32'(b_out_data), 32'h7FFF);
`else
        chk("t4p_b_data", 32'(b_out_data), 32'hFFFC);
`endif
        chk("t4p_b_ovf", 32'(b_ovf), 32'd1);
        chk("t4p_b_valid", 32'(b_out_valid), 32'd1);
        chk("t4p_a_data", 32'(out_data), 32'd65532);
        chk("t4p_a_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // -16384 x 4
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 15'h4000;   // -16384
        repeat (4) tick();
        in_valid = 1'b0;
`ifdef CASE_3_ACC_SAT_EN
        chk("t4n_b_data", 32'(b_out_data), 32'h8000);
`else
        chk("t4n_b_data", 32'(b_out_data), 32'h0000);
`endif
        chk("t4n_b_ovf", 32'(b_ovf), 32'd1);
        chk("t4n_a_data", 32'(out_data), 32'h00FF0000);
        chk("t4n_a_ovf", 32'(ovf), 32'd0);

        // Back-to-back: out_ready and start together in DONE
        out_ready = 1'b1; start = 1'b1; len = 8'd2;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_b_ovf_clr", 32'(b_ovf), 32'd0);
        in_valid = 1'b1; in_data = 15'd5;
        tick();
        in_data = 15'd6;
        tick();
        in_valid = 1'b0;
        chk("t5_out_valid2", 32'(out_valid), 32'd1);
        chk("t5_out_data", 32'(out_data), 32'd11);
        chk("t5_b_out_data", 32'(b_out_data), 32'd11);
        chk("t5_b_ovf", 32'(b_ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset after 2 of 5 products
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 15'd1;
        tick();
        in_data = 15'd2;
        tick();
        in_valid = 1'b0;
        chk("t6_pre_rst_data", 32'(out_data), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 15'd7;
        tick();
        in_valid = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd1);
        chk("t6_out_data", 32'(out_data), 32'd7);
        chk("t6_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
